// File: rtl/main_if.sv
// External array access bus: write port plus shared read data.
interface main_if #(
  parameter int AW = 10,
  parameter int DW = 64
);
  logic                 controlArr;
  logic                 controlArrWEnable_a;
  logic [AW-1:0]        controlArrAddr_a;
  logic signed [DW-1:0] controlArrWData_a;
  logic signed [DW-1:0] controlArrRData_a;

  modport master (
    output controlArr,
    output controlArrWEnable_a,
    output controlArrAddr_a,
    output controlArrWData_a,
    input  controlArrRData_a
  );

  modport slave (
    input  controlArr,
    input  controlArrWEnable_a,
    input  controlArrAddr_a,
    input  controlArrWData_a,
    output controlArrRData_a
  );
endinterface

// File: rtl/main.sv
// In-place prefix sum over a single-port synchronous RAM,
// with an external port that can take the RAM over at any time.
module main #(
  parameter int N  = 1000,
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_enable,
  input  logic [AW-1:0]        init_i_t_a,
  input  logic signed [DW-1:0] init_acc_t_a,
  output logic                 w_enable,
  output logic                 result,
  main_if.slave                bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_WR,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [AW-1:0]        r_i;
  logic signed [DW-1:0] r_acc;
  logic signed [DW-1:0] r_rdata;
  logic [DW-1:0]        r_mem [2**AW];

  logic [AW-1:0]        w_addr;
  logic                 w_we;
  logic signed [DW-1:0] w_wdata;
  logic signed [DW-1:0] w_sum;
  logic                 w_last;
  logic                 w_empty;

  assign w_sum   = r_acc + r_rdata;
  assign w_last  = (32'(r_i) + 32'd1) >= 32'(N);
  assign w_empty = 32'(init_i_t_a) >= 32'(N);

  always_comb begin
    w_addr  = r_i;
    w_we    = (r_state == S_WR);
    w_wdata = w_sum;
    if (bus.controlArr) begin
      w_addr  = bus.controlArrAddr_a;
      w_we    = bus.controlArrWEnable_a;
      w_wdata = bus.controlArrWData_a;
    end
  end

  // RAM is never reset; read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_addr] <= w_wdata;
    r_rdata <= r_mem[w_addr];
  end

  assign bus.controlArrRData_a = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_acc    <= '0;
      w_enable <= 1'b0;
      result   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (r_enable) begin
            r_i   <= init_i_t_a;
            r_acc <= init_acc_t_a;
            if (w_empty) begin
              r_state  <= S_DONE;
              w_enable <= 1'b1;
              result   <= 1'b1;
            end else begin
              r_state  <= S_RD;
              w_enable <= 1'b0;
              result   <= 1'b0;
            end
          end
        end
        S_RD: r_state <= S_WT;
        S_WT: r_state <= S_WR;
        S_WR: begin
          r_acc <= w_sum;
          r_i   <= r_i + 1'b1;
          if (w_last) begin
            r_state  <= S_DONE;
            w_enable <= 1'b1;
            result   <= 1'b1;
          end else begin
            r_state <= S_RD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main.sv
// Randomized prefix-sum bench: reference model plus read-data scoreboard.
module tb_main;
  localparam int N  = 1000;
  localparam int AW = 10;
  localparam int DW = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 r_enable = 1'b0;
  logic [AW-1:0]        init_i_t_a = '0;
  logic signed [DW-1:0] init_acc_t_a = '0;
  logic                 w_enable;
  logic                 result;

  main_if #(.AW(AW), .DW(DW)) u_if ();

  main #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r_enable     (r_enable),
    .init_i_t_a   (init_i_t_a),
    .init_acc_t_a (init_acc_t_a),
    .w_enable     (w_enable),
    .result       (result),
    .bus          (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic signed [DW-1:0] mdl [N];
  logic signed [DW-1:0] exp_q [$];
  int                   adr_q [$];
  bit                   rd_req = 1'b0;
  bit                   mon_vld = 1'b0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) mon_vld <= rd_req;

  always @(negedge clk) begin
    if (mon_vld) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 64'd1, 64'd0);
      end else begin
        automatic logic signed [DW-1:0] e = exp_q.pop_front();
        automatic int a = adr_q.pop_front();
        chk($sformatf("rd_arr[%0d]", a), u_if.controlArrRData_a, e);
      end
    end
  end

  function automatic void run_model(int ii, logic signed [DW-1:0] acc);
    for (int k = ii; k < N; k++) begin
      acc    = acc + mdl[k];
      mdl[k] = acc;
    end
  endfunction

  task automatic wr(int a, logic signed [DW-1:0] d);
    @(posedge clk); #1;
    u_if.controlArr          = 1'b1;
    u_if.controlArrWEnable_a = 1'b1;
    u_if.controlArrAddr_a    = AW'(a);
    u_if.controlArrWData_a   = d;
    mdl[a]                   = d;
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    u_if.controlArr          = 1'b0;
    u_if.controlArrWEnable_a = 1'b0;
    rd_req                   = 1'b0;
  endtask

  task automatic load_rand();
    for (int k = 0; k < N; k++) begin
      logic signed [31:0] t;
      t = $urandom;
      wr(k, DW'(t));
    end
    bus_idle();
  endtask

  task automatic readback();
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      u_if.controlArr          = 1'b1;
      u_if.controlArrWEnable_a = 1'b0;
      u_if.controlArrAddr_a    = AW'(k);
      rd_req                   = 1'b1;
      exp_q.push_back(mdl[k]);
      adr_q.push_back(k);
    end
    bus_idle();
    repeat (2) @(posedge clk);
  endtask

  task automatic start(int ii, logic signed [DW-1:0] acc, bit chk_drop);
    @(posedge clk); #1;
    r_enable     = 1'b1;
    init_i_t_a   = AW'(ii);
    init_acc_t_a = acc;
    @(posedge clk); #1;
    r_enable = 1'b0;
    if (chk_drop) chk("start_drop", {63'd0, w_enable}, 64'd0);
  endtask

  task automatic wait_done(string nm, int budget);
    int n = 0;
    while (w_enable !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done"}, {63'd0, w_enable}, 64'd1);
    chk({nm, "_result"}, {63'd0, result}, 64'd1);
  endtask

  task automatic full_run(string nm, int ii, logic signed [DW-1:0] acc);
    start(ii, acc, ii < N);
    run_model(ii, acc);
    wait_done(nm, 3 * (N - ii) + 3);
    readback();
  endtask

  initial begin
    u_if.controlArr          = 1'b0;
    u_if.controlArrWEnable_a = 1'b0;
    u_if.controlArrAddr_a    = '0;
    u_if.controlArrWData_a   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", {63'd0, w_enable}, 64'd0);
    chk("rst_result", {63'd0, result}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_wen", {63'd0, w_enable}, 64'd0);

    load_rand();
    full_run("basic", 0, '0);

    full_run("restart", $urandom_range(0, N - 1), {$urandom, $urandom});

    for (int k = 0; k < N; k++) wr(k, 64'sh7FFF_FFFF_FFFF_FFFF);
    bus_idle();
    full_run("wrap", 0, '0);

    load_rand();
    wr(998, 64'sd1);
    wr(999, 64'sd2);
    bus_idle();
    full_run("tail", 998, 64'sd5);

    full_run("empty", N, {$urandom, $urandom});

    load_rand();
    start(0, '0, 1'b1);
    run_model(0, '0);
    repeat (100) @(posedge clk);
    start(500, 64'sd7, 1'b0);
    wait_done("ignore", 3 * N + 3);
    readback();

    load_rand();
    start(0, '0, 1'b1);
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", {63'd0, w_enable}, 64'd0);
    chk("midrst_result", {63'd0, result}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_rand();
    full_run("after_rst", 0, '0);

    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("donerst_wen", {63'd0, w_enable}, 64'd0);
    chk("donerst_result", {63'd0, result}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_idle", {63'd0, w_enable}, 64'd0);
    full_run("keep", $urandom_range(0, N - 1), {$urandom, $urandom});

    repeat (3) @(posedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameter: N, default 1000, loop bound (number of array elements processed).
REQ-002 Parameter: AW, default 10, array address width; storage SHALL hold 2**AW words.
REQ-003 Parameter: DW, default 64, signed data width.
REQ-004 Port: clk  in  1  single clock; all logic SHALL use the rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: r_enable  in  1  start pulse; one cycle high SHALL start a run.
REQ-007 Port: init_i_t_a  in  AW  start index of the loop.
REQ-008 Port: init_acc_t_a  in  DW signed  initial accumulator value.
REQ-009 Port: w_enable  out  1  done flag.
REQ-010 Port: result  out  1  return value of the run.
REQ-011 Port: controlArr  in  1  1 gives the external port ownership of the array, 0 gives the internal FSM ownership.
REQ-012 Port: controlArrWEnable_a  in  1  external write enable.
REQ-013 Port: controlArrAddr_a  in  AW  external address.
REQ-014 Port: controlArrWData_a  in  DW signed  external write data.
REQ-015 Port: controlArrRData_a  out  DW signed  array read data; the external port and the FSM SHALL share this read data.

Function
REQ-016 The array SHALL be a single-port synchronous RAM of 2**AW x DW.
- Write: committed at the rising edge when the write enable is high.
- Read: data for the address presented at edge k SHALL appear on controlArrRData_a after edge k+1 (1-cycle latency); reads SHALL also occur on write cycles.
REQ-017 Port mux:
- controlArr=1: address, write enable and write data SHALL come from the controlArr*_a inputs.
- controlArr=0: they SHALL come from the FSM.
- controlArr SHALL override the FSM in every state; the FSM SHALL NOT stall because of it.
REQ-018 Computation (in-place prefix sum) SHALL run from i=init_i_t_a while i<N: acc = acc + arr[i]; arr[i] = acc; i = i+1.
- acc SHALL start at init_acc_t_a.
- Addition SHALL be DW-bit two's-complement with wrap-around and no saturation.
REQ-019 FSM states: IDLE, RD (issue read arr[i]), WT (data returns), WR (write acc+data to arr[i], increment i), DONE.
REQ-020 FSM transitions:
- IDLE -> RD on r_enable, latching init_i_t_a and init_acc_t_a.
- RD -> WT -> WR.
- WR -> RD if i+1<N, otherwise WR -> DONE.
REQ-021 If init_i_t_a >= N at start, the FSM SHALL go IDLE -> DONE directly and leave the array unmodified.
REQ-022 Throughput SHALL be at most 3 cycles per element; w_enable SHALL rise no later than 3*(N-init_i)+3 cycles after the r_enable edge.
REQ-023 In DONE:
- w_enable SHALL be 1 and result SHALL be 1'b1.
- Both SHALL hold until the next r_enable or reset.
REQ-024 w_enable and result SHALL be 0 in all states other than DONE.
REQ-025 r_enable SHALL be ignored in RD, WT and WR.
REQ-026 r_enable in DONE SHALL restart exactly as from IDLE; w_enable SHALL drop at the next edge.
REQ-027 After DONE, the array SHALL be readable via controlArr=1 with the 1-cycle latency of REQ-016.

Reset
REQ-028 rst_n=0 SHALL immediately force:
- state IDLE;
- w_enable=0, result=0;
- i and acc = 0.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-run SHALL abort the run; array words already written SHALL keep their written values.
REQ-031 After rst_n deasserts, the block SHALL wait in IDLE for r_enable.

Verification
REQ-032 Load arr[0..999] through controlArr=1 with random signed 32-bit values, then pulse r_enable with init_i=0 and init_acc=0 -> w_enable rises within 3003 cycles; readback arr[k] equals sum(arr0[0..k]) for all k; result=1.
REQ-033 arr all = 0x7FFFFFFFFFFFFFFF, init 0 -> arr[1] wraps to -2; all following values follow 64-bit wrap.
REQ-034 init_i=998, init_acc=5, arr[998]=1, arr[999]=2 -> arr[998]=6, arr[999]=8; arr[0..997] unchanged.
REQ-035 init_i=1000 -> w_enable rises within 2 cycles; array unchanged.
REQ-036 Assert rst_n=0 mid-run -> w_enable=0 at once; a new r_enable after release produces a correct full run.
REQ-037 r_enable pulsed during a run -> ignored; final results match the first run only.
